// File: rtl/chacha20_stream_ctrl_if.sv
// Handshake bundle between the ChaCha20 stream sequencer and its surroundings:
// the start request, the block-function handshake, the serialiser controls
// and the XOR-stage word transfer.
interface chacha20_stream_ctrl_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [31:0]      init_counter;
  logic [LEN_W-1:0] msg_words;
  logic             busy;
  logic             bf_start;
  logic [31:0]      bf_counter;
  logic             bf_done;
  logic             ser_load;
  logic             ser_valid;
  logic             xor_ready;
  logic             xor_en;
  logic             ser_flush;
  logic [3:0]       word_idx;
  logic             done;
  logic             err;

  // Sequencer side.
  modport slave (
    input  start, init_counter, msg_words, bf_done, ser_valid, xor_ready,
    output busy, bf_start, bf_counter, ser_load, xor_en, ser_flush,
           word_idx, done, err
  );

  // Environment side: requester, block function, serialiser, XOR stage.
  modport master (
    output start, init_counter, msg_words, bf_done, ser_valid, xor_ready,
    input  busy, bf_start, bf_counter, ser_load, xor_en, ser_flush,
           word_idx, done, err
  );
endinterface

// File: rtl/chacha20_stream_ctrl.sv
// ChaCha20 keystream sequencer: requests one block per 16 words, loads the
// serialiser, counts consumed words, flushes an unused tail and reports
// completion or block-counter exhaustion.
module chacha20_stream_ctrl #(
  parameter int LEN_W       = 16,
  parameter int BLOCK_WORDS = 16
) (
  input logic                  clk,
  input logic                  rst,
  chacha20_stream_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_LOAD,
    S_STREAM,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_e;

  state_e           state_q;
  logic [31:0]      ctr_q;
  logic [LEN_W-1:0] rem_q;
  logic [IDX_W-1:0] widx_q;
  logic             bf_start_q;
  logic             ser_load_q;
  logic             ser_flush_q;
  logic             done_q;
  logic             err_q;

  logic [31:0]      ctr_d;
  logic [LEN_W-1:0] rem_d;
  logic [IDX_W-1:0] widx_d;
  logic             xfer;
  logic             last_word;
  logic             last_rem;

  // Word transfer and next-value arithmetic used by the stream state.
  assign xfer      = (state_q == S_STREAM) && bus.ser_valid && bus.xor_ready;
  assign ctr_d     = ctr_q + 32'd1;
  assign rem_d     = rem_q - LEN_W'(1);
  assign widx_d    = widx_q + IDX_W'(1);
  assign last_word = (widx_q == IDX_W'(BLOCK_WORDS - 1));
  assign last_rem  = (rem_q == LEN_W'(1));

  // Sequencer FSM with registered one-cycle pulses and sticky error flag.
  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // blocking assignments would make later lines read already-updated state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ctr_q       <= '0;
      rem_q       <= '0;
      widx_q      <= '0;
      bf_start_q  <= 1'b0;
      ser_load_q  <= 1'b0;
      ser_flush_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bf_start_q  <= 1'b0;
      ser_load_q  <= 1'b0;
      ser_flush_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            ctr_q <= bus.init_counter;
            rem_q <= bus.msg_words;
            err_q <= 1'b0;
            if (bus.msg_words == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_GEN;
              bf_start_q <= 1'b1;
            end
          end
        end
        S_GEN: begin
          // bf_done is accepted on any GEN cycle, including the bf_start one.
          if (bus.bf_done) begin
            state_q    <= S_LOAD;
            ser_load_q <= 1'b1;
            widx_q     <= '0;
          end
        end
        S_LOAD: state_q <= S_STREAM;
        S_STREAM: begin
          if (xfer) begin
            rem_q  <= rem_d;
            widx_q <= widx_d;
            if (last_rem) begin
              if (last_word) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q     <= S_FLUSH;
                ser_flush_q <= 1'b1;
              end
            end else if (last_word) begin
              // The block counter must never wrap; exhaustion is an error.
              if (ctr_q == 32'hFFFF_FFFF) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
                done_q  <= 1'b1;
              end else begin
                ctr_q      <= ctr_d;
                state_q    <= S_GEN;
                bf_start_q <= 1'b1;
              end
            end
          end
        end
        S_FLUSH: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.bf_start   = bf_start_q;
  assign bus.bf_counter = ctr_q;
  assign bus.ser_load   = ser_load_q;
  assign bus.xor_en     = xfer;
  assign bus.ser_flush  = ser_flush_q;
  assign bus.word_idx   = 4'(widx_q);
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_chacha20_stream_ctrl.sv
// Directed bench for the ChaCha20 stream sequencer with a block-function
// model and a scoreboard of expected block counters and word indices.
module tb_chacha20_stream_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  chacha20_stream_ctrl_if #(.LEN_W(16)) bus ();

  chacha20_stream_ctrl #(.LEN_W(16), .BLOCK_WORDS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_ctr_q[$];
  logic [3:0]  exp_idx_q[$];

  int cyc = 0;
  int n_bf, n_load, n_xor, n_flush, n_done, n_unexp;
  int last_xor_cyc, flush_cyc, done_cyc, start_cyc;
  logic done_err;
  logic [31:0] bf_seen;
  int bf_lat = 10;
  int bf_cnt = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Block-function model: bf_done pulses bf_lat cycles after bf_start.
  always @(posedge clk) begin
    #1;
    bus.bf_done = 1'b0;
    if (bf_cnt > 0) bf_cnt--;
    if (bf_cnt == 0) begin
      bus.bf_done = 1'b1;
      bf_cnt = -1;
    end
    if (bus.bf_start) begin
      if (bf_lat == 0) bus.bf_done = 1'b1;
      else bf_cnt = bf_lat;
    end
  end

  // Output monitor: compares block counters and word indices against the scoreboard.
  always @(negedge clk) begin
    if (bus.bf_start) begin
      n_bf++;
      bf_seen = bus.bf_counter;
      if (exp_ctr_q.size() == 0) n_unexp++;
      else check("bf_counter", 64'(bus.bf_counter), 64'(exp_ctr_q.pop_front()));
    end
    if (bus.bf_done && bus.busy) check("bf_counter_hold", 64'(bus.bf_counter), 64'(bf_seen));
    if (bus.ser_load) n_load++;
    if (bus.xor_en) begin
      n_xor++;
      last_xor_cyc = cyc;
      if (exp_idx_q.size() == 0) n_unexp++;
      else check("word_idx", 64'(bus.word_idx), 64'(exp_idx_q.pop_front()));
    end
    if (bus.ser_flush) begin
      n_flush++;
      flush_cyc = cyc;
    end
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
      done_err = bus.err;
    end
  end

  task automatic clear_counts();
    n_bf = 0; n_load = 0; n_xor = 0; n_flush = 0; n_done = 0; n_unexp = 0;
    last_xor_cyc = -1; flush_cyc = -1; done_cyc = -1;
  endtask

  // Scoreboard model: one counter per block until the counter would exceed 2^32-1.
  task automatic push_msg(input logic [31:0] init, input int words);
    longint c;
    int rem = words;
    c = longint'(init);
    while (rem > 0 && c <= 64'hFFFF_FFFF) begin
      exp_ctr_q.push_back(32'(c));
      for (int i = 0; i < 16 && rem > 0; i++) begin
        exp_idx_q.push_back(4'(i));
        rem--;
      end
      c++;
    end
  endtask

  task automatic do_start(input logic [31:0] init, input logic [15:0] words);
    bus.start = 1'b1;
    bus.init_counter = init;
    bus.msg_words = words;
    start_cyc = cyc;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget, input bit toggle);
    int n = 0;
    while (n_done < target && n < budget) begin
      @(posedge clk); #2;
      if (toggle) bus.xor_ready = ~bus.xor_ready;
      n++;
    end
    bus.xor_ready = 1'b1;
    check({tag, "_done_seen"}, 64'(n_done), 64'(target));
  endtask

  task automatic wait_xor(input string tag, input int target, input int budget);
    int n = 0;
    while (n_xor < target && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_xor_reached"}, 64'(n_xor >= target), 64'd1);
  endtask

  task automatic end_step(input string tag, input int e_bf, input int e_xor, input int e_flush);
    check({tag, "_bf_starts"}, 64'(n_bf), 64'(e_bf));
    check({tag, "_ser_loads"}, 64'(n_load), 64'(e_bf));
    check({tag, "_xor_words"}, 64'(n_xor), 64'(e_xor));
    check({tag, "_flushes"}, 64'(n_flush), 64'(e_flush));
    check({tag, "_unexpected"}, 64'(n_unexp), 64'd0);
    check({tag, "_left_ctr"}, 64'(exp_ctr_q.size()), 64'd0);
    check({tag, "_left_idx"}, 64'(exp_idx_q.size()), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.init_counter = '0;
    bus.msg_words = '0;
    bus.bf_done = 1'b0;
    bus.ser_valid = 1'b1;
    bus.xor_ready = 1'b1;
    clear_counts();

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", 64'({bus.busy, bus.bf_start, bus.bf_counter, bus.ser_load, bus.xor_en,
                                bus.ser_flush, bus.word_idx, bus.done, bus.err}), 64'd0);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_no_pulses", 64'(n_bf + n_load + n_xor + n_flush + n_done), 64'd0);

    // Single block of 16 words.
    clear_counts();
    push_msg(32'd1, 16);
    do_start(32'd1, 16'd16);
    check("single_busy", 64'(bus.busy), 64'd1);
    wait_done("single", 1, 200, 1'b0);
    end_step("single", 1, 16, 0);
    check("single_done_timing", 64'(done_cyc), 64'(last_xor_cyc + 1));

    // Partial tail: 20 words over two blocks.
    clear_counts();
    push_msg(32'd7, 20);
    do_start(32'd7, 16'd20);
    wait_done("tail", 1, 300, 1'b0);
    end_step("tail", 2, 20, 1);
    check("tail_flush_timing", 64'(flush_cyc), 64'(last_xor_cyc + 1));
    check("tail_done_timing", 64'(done_cyc), 64'(flush_cyc + 1));

    // Zero length: done with no block request.
    clear_counts();
    do_start(32'd5, 16'd0);
    wait_done("zero", 1, 20, 1'b0);
    end_step("zero", 0, 0, 0);
    check("zero_done_timing", 64'((done_cyc - start_cyc) inside {[1:2]}), 64'd1);

    // Start while busy is ignored; block function answers in the bf_start cycle.
    clear_counts();
    bf_lat = 0;
    push_msg(32'd3, 16);
    do_start(32'd3, 16'd16);
    wait_xor("busy", 4, 100);
    bus.start = 1'b1;
    bus.init_counter = 32'd99;
    bus.msg_words = 16'd5;
    @(posedge clk); #2;
    bus.start = 1'b0;
    wait_done("busy", 1, 200, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    end_step("busy", 1, 16, 0);
    check("busy_single_done", 64'(n_done), 64'd1);
    check("busy_idle_after", 64'(bus.busy), 64'd0);
    bf_lat = 10;

    // Backpressure: xor_ready toggles every cycle.
    clear_counts();
    push_msg(32'd40, 16);
    do_start(32'd40, 16'd16);
    wait_done("bp", 1, 400, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    end_step("bp", 1, 16, 0);
    check("bp_single_done", 64'(n_done), 64'd1);

    // Counter exhaustion.
    clear_counts();
    push_msg(32'hFFFF_FFFF, 17);
    do_start(32'hFFFF_FFFF, 16'd17);
    wait_done("exh", 1, 300, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    end_step("exh", 1, 16, 0);
    check("exh_err_with_done", 64'(done_err), 64'd1);
    check("exh_err_sticky", 64'(bus.err), 64'd1);
    check("exh_done_timing", 64'(done_cyc), 64'(last_xor_cyc + 1));

    // Next accepted start clears err.
    clear_counts();
    push_msg(32'd5, 1);
    do_start(32'd5, 16'd1);
    check("clr_err_cleared", 64'(bus.err), 64'd0);
    wait_done("clr", 1, 100, 1'b0);
    end_step("clr", 1, 1, 1);

    // Reset mid-operation.
    clear_counts();
    push_msg(32'd11, 16);
    do_start(32'd11, 16'd16);
    wait_xor("midrst", 3, 100);
    rst = 1'b0;
    #1;
    check("midrst_outputs", 64'({bus.busy, bus.bf_start, bus.bf_counter, bus.ser_load, bus.xor_en,
                                 bus.ser_flush, bus.word_idx, bus.done, bus.err}), 64'd0);
    exp_ctr_q.delete();
    exp_idx_q.delete();
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("midrst_no_done_flush", 64'(n_done + n_flush), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chacha20_stream_ctrl.md
Name: chacha20_stream_ctrl

Overview:
- Sequencer for the ChaCha20 keystream datapath: block function, block counter and serialiser.
- Takes a start request with an initial block counter and a message length in 32-bit words.
- Issues one block-generation request per 16-word block, loads each result into the serialiser, and counts keystream words as the downstream XOR stage consumes them.
- Flushes an unused block tail and signals completion, or raises an error on counter exhaustion.

Parameters:
LEN_W, 16, width of the message-length input in 32-bit words (max message 2^LEN_W-1 words)
BLOCK_WORDS, 16, keystream words per ChaCha20 block; fixed at 16; word_idx width is $clog2(BLOCK_WORDS)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
init_counter  in  32  first block counter value, captured on accepted start
msg_words  in  LEN_W  message length in words, captured on accepted start
busy  out  1  high in every state except IDLE
bf_start  out  1  one-cycle pulse: block function computes block for bf_counter
bf_counter  out  32  block counter presented to block function; held stable from bf_start until bf_done
bf_done  in  1  block function result valid (one-cycle pulse)
ser_load  out  1  one-cycle pulse: serialiser captures the 4x4 block matrix
ser_valid  in  1  serialiser presents a keystream word
xor_ready  in  1  XOR stage can accept a word
xor_en  out  1  word transfer this cycle = (state==STREAM) & ser_valid & xor_ready
ser_flush  out  1  one-cycle pulse: serialiser discards the remaining words of the current block
word_idx  out  4  index of the current word within the block, 0..15
done  out  1  one-cycle pulse at end of message
err  out  1  sticky counter-exhaustion flag; cleared by the next accepted start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; bf_counter=0; internal counters cleared.
- States: IDLE, GEN, LOAD, STREAM, FLUSH, DONE, ERR.
- IDLE:
  - start=1 captures init_counter into ctr and msg_words into rem.
  - If msg_words==0: go to DONE, with no bf_start issued.
  - Otherwise: go to GEN; err is cleared the same cycle.
- GEN:
  - bf_start is high on the first GEN cycle only; bf_counter=ctr.
  - Wait for bf_done; then go to LOAD.
  - A bf_done arriving in the same cycle as bf_start is accepted.
- LOAD:
  - ser_load=1 for exactly one cycle.
  - word_idx=0; then go to STREAM.
- STREAM, on each xor_en cycle:
  - rem decrements by 1 and word_idx increments.
  - If rem reaches 0 and word_idx was 15: go to DONE.
  - If rem reaches 0 and word_idx <15: go to FLUSH.
  - If word_idx was 15 and rem>0:
    - ctr==0xFFFFFFFF: go to ERR; the counter never wraps.
    - Otherwise: ctr increments by 1 and the state goes to GEN.
  - No xor_en: hold all state. Backpressure from xor_ready is unbounded.
- FLUSH: ser_flush=1 for one cycle; then go to DONE.
- DONE: done=1 for one cycle; then go to IDLE.
- ERR: err set to 1; done pulses in the same cycle; then go to IDLE. err stays 1 until the next accepted start.
- start outside IDLE is ignored; no queueing.
- Reset mid-operation: immediate return to IDLE with outputs cleared. No done or flush pulse is issued.
- Latency, from accepted start to the first possible xor_en: 1 (GEN) + block function latency + 1 (LOAD) + 1 cycles.
- Width rules: ctr is 32-bit with no wrap; rem is LEN_W bits; word_idx is a 4-bit wrapping count, reset to 0 at each LOAD.
- Maximum of 1 outstanding block request at any time.

Test Plan:
- Reset check: assert rst=0 mid-cycle -> all outputs 0 immediately; after release, busy=0 and no pulses occur without start.
- Single block: start, init_counter=1, msg_words=16, xor_ready=1, bf_done 10 cycles after bf_start -> one bf_start with bf_counter=1, one ser_load, 16 xor_en cycles, no ser_flush, done one cycle after the 16th word.
- Partial tail: msg_words=20, init_counter=7 -> bf_counter=7 then 8, 20 xor_en total, ser_flush after word_idx=3 of block 2, then done.
- Zero length plus start while busy: msg_words=0 -> done 2 cycles after start with no bf_start; a second start pulsed during STREAM of another message -> ignored, counts unchanged.
- Backpressure: msg_words=16, xor_ready toggling 1/0 each cycle -> exactly 16 xor_en, word_idx advances only on xor_en, done pulses once.
- Counter exhaustion: init_counter=0xFFFFFFFF, msg_words=17 -> 16 words streamed, then err=1 plus a done pulse, no second bf_start; next start with msg_words=1 clears err.
